rs_enc_stream_ctrl: RTL

//  Streaming controller for a systematic RS(N,K) encoder built around an external parity LFSR.

---
 rtl/rs_enc_stream_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rs_enc_stream_ctrl.sv
// ============================================================================
// Module      : rs_enc_stream_ctrl
// Description : Streaming controller for a systematic RS(N,K) encoder that
//               drives an external parity LFSR. Takes K message symbols,
//               echoes them out, then drains N-K parity symbols from the
//               LFSR with SOP/EOP/parity flags and downstream back-pressure.
//               Optional feature macro: RS_SHORTEN_EN (per-codeword k_len).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_enc_stream_ctrl #(
  parameter int SYM_W = 8,
  parameter int N     = 255,
  parameter int K     = 239,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active low
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SYM_W-1:0]   in_data,
`ifdef RS_SHORTEN_EN
  input  logic [CNT_W-1:0]   k_len,
`endif
  input  logic [SYM_W-1:0]   lfsr_top,
  output logic [SYM_W-1:0]   lfsr_fb,
  output logic               lfsr_en,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [SYM_W-1:0]   out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic               out_par,
  output logic [15:0]        cw_count
);

  localparam logic [CNT_W-1:0] C_K   = CNT_W'(K);
  localparam logic [CNT_W-1:0] C_NK  = CNT_W'(N - K);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    MSG = 1'b0,
    PAR = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   sym_cnt;
  logic [CNT_W-1:0]   sym_cnt_nxt;
  logic [CNT_W-1:0]   kl_eff;
  logic [CNT_W-1:0]   last_idx;
  logic               adv;
  logic               accept;
  logic               first_sym;
  logic               last_par;

  // The output register may load whenever it is empty or being drained.
  assign adv       = out_ready | ~out_valid;
  // Written without in_ready so the handshake has no combinational loop.
  assign accept    = in_valid & adv & (state == MSG);
  assign first_sym = (sym_cnt == '0);

`ifdef RS_SHORTEN_EN
  logic [CNT_W-1:0] kl_reg;
  logic [CNT_W-1:0] k_len_sat;

  // Out-of-range lengths fall back to the full message length.
  assign k_len_sat = ((k_len == '0) || (k_len > C_K)) ? C_K : k_len;
  // On the first symbol the freshly sampled length must already steer the
  // MSG->PAR decision (matters for a 1-symbol message).
  assign kl_eff    = ((state == MSG) && first_sym) ? k_len_sat : kl_reg;

  // Latch the message length of the codeword on its first accepted symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kl_reg <= C_K;
    end else if (accept && first_sym) begin
      kl_reg <= k_len_sat;
    end
  end
`else
  assign kl_eff = C_K;
`endif

  assign last_idx = kl_eff + C_NK - C_ONE;
  assign last_par = (state == PAR) && (sym_cnt == last_idx);

  // State and symbol counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= MSG;
      sym_cnt <= '0;
    end else begin
      state   <= state_nxt;
      sym_cnt <= sym_cnt_nxt;
    end
  end

  // Next-state logic plus LFSR control and input handshake.
  always_comb begin
    state_nxt   = state;
    sym_cnt_nxt = sym_cnt;
    in_ready    = 1'b0;
    lfsr_fb     = '0;
    lfsr_en     = 1'b0;
    case (state)
      MSG: begin
        in_ready = adv;
        lfsr_fb  = in_data ^ lfsr_top;
        lfsr_en  = accept;
        if (accept) begin
          sym_cnt_nxt = sym_cnt + C_ONE;
          if (sym_cnt == (kl_eff - C_ONE)) begin
            state_nxt = PAR;
          end
        end
      end
      PAR: begin
        // Zero feedback: the LFSR empties itself while parity drains.
        if (adv) begin
          lfsr_en = 1'b1;
          if (last_par) begin
            sym_cnt_nxt = '0;
            state_nxt   = MSG;
          end else begin
            sym_cnt_nxt = sym_cnt + C_ONE;
          end
        end
      end
      default: begin
        state_nxt   = MSG;
        sym_cnt_nxt = '0;
      end
    endcase
  end

  // Registered codeword output stream and completed-codeword counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_par   <= 1'b0;
      cw_count  <= '0;
    end else if (adv) begin
      if (state == MSG) begin
        if (accept) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
          out_par   <= 1'b0;
          out_sop   <= first_sym;
          out_eop   <= 1'b0;
        end else begin
          out_valid <= 1'b0;
          out_sop   <= 1'b0;
          out_eop   <= 1'b0;
        end
      end else begin
        out_valid <= 1'b1;
        out_data  <= lfsr_top;
        out_par   <= 1'b1;
        out_sop   <= 1'b0;
        out_eop   <= last_par;
        if (last_par) begin
          cw_count <= cw_count + 16'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
